neuron_accumulator: RTL and testbench
=====================================

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, total word width in sign-magnitude (bit WIDTH-1 = sign).
REQ-002 SHALL have parameter INT, default 6, integer field width including the sign bit.
REQ-003 SHALL have parameter FRAC, default 10, fraction bits; WIDTH = INT + FRAC.
REQ-004 SHALL have parameter NUM_INPUTS, default 2, products summed per neuron evaluation (>=1).
REQ-005 SHALL have clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have start  input  1  begin a new evaluation and load bias.
REQ-008 SHALL have bias  input  WIDTH  neuron bias, sign-magnitude, sampled when start is accepted.
REQ-009 SHALL have prod_valid  input  1  prod/prod_ovf valid this cycle.
REQ-010 SHALL have prod  input  WIDTH  weight*input product from the upstream multiplier, sign-magnitude.
REQ-011 SHALL have prod_ovf  input  1  overflow flag accompanying prod.
REQ-012 SHALL have prod_ready  output  1  block accepts a product this cycle.
REQ-013 SHALL have out_valid  output  1  result/ovf valid.
REQ-014 SHALL have out_ready  input  1  downstream accepts result.
REQ-015 SHALL have result  output  WIDTH  neuron sum, sign-magnitude.
REQ-016 SHALL have ovf  output  1  sticky overflow for the current evaluation.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-018 IDLE: prod_ready=0, out_valid=0; start=1 loads acc<=bias, cnt<=0, ovf<=0, goes to ACCUM.
REQ-019 ACCUM: prod_ready=1; a product is accepted only when prod_valid && prod_ready.
REQ-020 On accept, acc<=sat(acc+prod), ovf<=ovf|prod_ovf|clamp, cnt<=cnt+1; accept with cnt==NUM_INPUTS-1 goes to DONE.
REQ-021 Accumulator SHALL be two's complement with at least WIDTH+1 bits; sign-magnitude inputs converted before add.
REQ-022 sat() SHALL clamp to +/-(2^(WIDTH-1)-1) LSB (0x7FFF/0xFFFF magnitude at default); clamp=1 when clamping occurs, applied after every add.
REQ-023 Input -0 (sign set, magnitude 0) SHALL be treated as 0; result zero SHALL always be encoded 0x0000.
REQ-024 DONE: out_valid=1, prod_ready=0; result/ovf held stable until out_valid && out_ready, then IDLE.
REQ-025 DONE with out_ready=1 and start=1 in the same cycle SHALL go directly to ACCUM loading the new bias (back-to-back).
REQ-026 start SHALL be ignored in ACCUM and in DONE without out_ready.
REQ-027 Latency: out_valid asserts on the cycle after the final product is accepted.
REQ-028 prod_valid in IDLE/DONE SHALL be ignored (no accumulation, no ovf change).

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, acc=0, cnt=0, result=0x0000, ovf=0, out_valid=0, prod_ready=0, regardless of state.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL begin a fresh evaluation.

Configuration
REQ-031 Macro RELU_EN defined: a negative final sum SHALL output result=0x0000 (ovf unaffected); positive sums unchanged.
REQ-032 RELU_EN undefined: result SHALL be the signed saturated sum in sign-magnitude.

Verification
REQ-033 bias 0x0000, prods 0x0066, 0x0600 -> result 0x0666, ovf 0, out_valid one cycle after 2nd accept.
REQ-034 bias 0x0400, prods 0x8600, 0x8066 -> result 0x8266 (RELU_EN undefined) / 0x0000 (RELU_EN defined), ovf 0.
REQ-035 bias 0x7C00, prods 0x0800, 0x8400 -> clamp on 1st add, result 0x7BFF, ovf 1.
REQ-036 bias 0x0000, prods 0x0066 with prod_ovf=1, 0x000A -> result 0x0070, ovf 1; next evaluation starts with ovf 0.
REQ-037 out_ready held 0 for 5 cycles in DONE with prod_valid=1 -> result/ovf stable, prod_ready 0, no accumulation; out_ready+start together -> ACCUM next cycle.
REQ-038 rst pulse after one accepted product in ACCUM -> all outputs 0 asynchronously, state IDLE; new start then bias 0x0400, prods 0x0400, 0x0400 -> result 0x0C00.

Source files
------------

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: bias + NUM_INPUTS sign-magnitude products, saturated after every add.
// Optional macro RELU_EN clamps negative final sums to zero on the result port.
module neuron_accumulator #(
  parameter int WIDTH      = 16,
  parameter int INT        = 6,
  parameter int FRAC       = 10,
  parameter int NUM_INPUTS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bias,
  input  logic             prod_valid,
  input  logic [WIDTH-1:0] prod,
  input  logic             prod_ovf,
  output logic             prod_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  if (INT + FRAC != WIDTH) begin : g_bad_fmt
    $error("neuron_accumulator: INT + FRAC must equal WIDTH");
  end

  localparam int AW = WIDTH + 1;
  localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef logic signed [AW-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam acc_t MAXV = acc_t'({2'b00, {(WIDTH-1){1'b1}}});
  localparam acc_t MINV = -MAXV;
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);

  // -0 maps to 0 naturally since only the magnitude is negated
  function automatic acc_t sm2tc(input logic [WIDTH-1:0] x);
    acc_t m;
    m = acc_t'({2'b00, x[WIDTH-2:0]});
    return x[WIDTH-1] ? -m : m;
  endfunction

  state_t        state, nxt;
  acc_t          acc, sum, sat;
  logic [CW-1:0] cnt;
  logic          load, accept, clamp;
  logic [AW-1:0] mag;
  logic [1:0]    unused_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    load       = 1'b0;
    accept     = 1'b0;
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          nxt  = ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          accept = 1'b1;
          if (cnt == LAST) nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          load = start;
          nxt  = start ? ACCUM : IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Saturating add; acc is always within +/-MAXV so AW bits cannot wrap
  always_comb begin
    sum   = acc + sm2tc(prod);
    sat   = sum;
    clamp = 1'b0;
    if (sum > MAXV) begin
      sat   = MAXV;
      clamp = 1'b1;
    end else if (sum < MINV) begin
      sat   = MINV;
      clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= sm2tc(bias);
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sat;
      cnt <= cnt + CW'(1);
      ovf <= ovf | prod_ovf | clamp;
    end
  end

  // Negative acc is never zero, so the sign bit never produces -0
  always_comb begin
    mag        = acc[AW-1] ? -acc : acc;
    unused_mag = mag[AW-1:WIDTH-1];
`ifdef RELU_EN
    result     = acc[AW-1] ? '0 : {1'b0, mag[WIDTH-2:0]};
`else
    result     = {acc[AW-1], mag[WIDTH-2:0]};
`endif
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized bench for neuron_accumulator against an integer reference model.
module tb_neuron_accumulator;
  logic        clk, rst, start, prod_valid, prod_ovf, out_ready;
  logic [15:0] bias, prod, result;
  logic        prod_ready, out_valid, ovf;

  int n_cmp = 0;
  int n_err = 0;
  int m_sum;
  bit m_ovf;
  logic [15:0] p_q[$];
  bit          o_q[$];

  neuron_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .prod_valid(prod_valid), .prod(prod), .prod_ovf(prod_ovf),
    .prod_ready(prod_ready), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sm2i(input logic [15:0] x);
    int m;
    m = int'({17'b0, x[14:0]});
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] i2sm(input int v);
`ifdef RELU_EN
    if (v < 0) return 16'h0000;
`endif
    if (v < 0) return {1'b1, 15'(-v)};
    return {1'b0, 15'(v)};
  endfunction

  function automatic logic [15:0] rand_sm();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom % 4)
      0: ;
      1: r = {r[15], 5'b0, r[9:0]};
      2: r = {r[15], 15'b0};
      default: r = {r[15], 7'h7F, r[7:0]};
    endcase
    return r;
  endfunction

  task automatic start_eval(input logic [15:0] b, input bit from_done);
    start = 1'b1;
    bias = b;
    out_ready = from_done;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    m_sum = sm2i(b);
    m_ovf = 1'b0;
    chk("start_ready", prod_ready, 1);
    chk("start_noval", out_valid, 0);
    chk("start_ovf_clr", ovf, 0);
  endtask

  task automatic feed(input int hold, input bit junk);
    logic [15:0] exp;
    for (int i = 0; i < p_q.size(); i++) begin
      if (junk) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          prod_valid = 1'b0;
          start = 1'($urandom);
          bias = 16'($urandom);
          prod = 16'($urandom);
          @(posedge clk); #1;
          start = 1'b0;
          chk("gap_ready", prod_ready, 1);
        end
      end
      prod_valid = 1'b1;
      prod = p_q[i];
      prod_ovf = o_q[i];
      @(posedge clk); #1;
      prod_valid = 1'b0;
      prod_ovf = 1'b0;
      m_sum += sm2i(p_q[i]);
      if (m_sum > 32767) begin m_sum = 32767; m_ovf = 1'b1; end
      if (m_sum < -32767) begin m_sum = -32767; m_ovf = 1'b1; end
      if (o_q[i]) m_ovf = 1'b1;
      chk("out_valid", out_valid, (i == p_q.size() - 1) ? 1 : 0);
    end
    exp = i2sm(m_sum);
    chk("result", result, exp);
    chk("ovf", ovf, m_ovf);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      prod_valid = 1'b1;
      prod = 16'($urandom);
      prod_ovf = 1'b1;
      start = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_result", result, exp);
      chk("hold_ovf", ovf, m_ovf);
      chk("hold_ready", prod_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    prod_valid = 1'b0;
    prod_ovf = 1'b0;
    start = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_valid", out_valid, 0);
    chk("rel_ready", prod_ready, 0);
  endtask

  initial begin
    bit in_done;
    rst = 1'b1; start = 1'b0; bias = '0; prod_valid = 1'b0;
    prod = '0; prod_ovf = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_ready", prod_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", prod_ready, 0);

    p_q = '{16'h0066, 16'h0600}; o_q = '{0, 0};
    start_eval(16'h0000, 0); feed(0, 0); release_out();
    p_q = '{16'h8600, 16'h8066}; o_q = '{0, 0};
    start_eval(16'h0400, 0); feed(0, 0); release_out();
    p_q = '{16'h0800, 16'h8400}; o_q = '{0, 0};
    start_eval(16'h7C00, 0); feed(0, 0); release_out();
    p_q = '{16'h0066, 16'h000A}; o_q = '{1, 0};
    start_eval(16'h0000, 0); feed(5, 0);
    p_q = '{16'h8000, 16'h0001}; o_q = '{0, 0};
    start_eval(16'h8000, 1); feed(1, 0); release_out();

    // Reset in the middle of an evaluation
    start_eval(16'h1234, 0);
    prod_valid = 1'b1; prod = 16'h0100;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", prod_ready, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_ovf", ovf, 0);
    rst = 1'b0;
    p_q = '{16'h0400, 16'h0400}; o_q = '{0, 0};
    start_eval(16'h0400, 0); feed(0, 0);
    chk("post_rst_sum", result, 16'h0C00);
    release_out();

    in_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] b;
      p_q = '{rand_sm(), rand_sm()};
      o_q = '{($urandom % 8) == 0, ($urandom % 8) == 0};
      b = rand_sm();
      if (in_done && ($urandom % 2) == 1) start_eval(b, 1);
      else begin
        if (in_done) release_out();
        start_eval(b, 0);
      end
      feed($urandom_range(0, 3), 1);
      in_done = 1'b1;
    end
    release_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
